// File: rtl/lpc_host_ctrl.sv
// LPC host for 8-bit I/O read/write cycles: accepts one command over valid/ready,
// runs the LPC frame on lframe_o/lad_bus and returns a one-clock response strobe.
module lpc_host_ctrl #(
  parameter int SYNC_TIMEOUT = 8,
  parameter int LWAIT_MAX    = 255
) (
  input  logic        clk_i,
  input  logic        nrst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [15:0] cmd_addr_i,
  input  logic [7:0]  cmd_wdata_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        lframe_o,
  inout  wire  [3:0]  lad_bus
);

  localparam int TW = $clog2(SYNC_TIMEOUT + 1);
  localparam int LW = $clog2(LWAIT_MAX + 1);

  typedef enum logic [4:0] {
    S_IDLE, S_START, S_CYCTYPE, S_ADDR0, S_ADDR1, S_ADDR2, S_ADDR3,
    S_WDATA0, S_WDATA1, S_TAR1, S_TAR2, S_SYNC, S_RDATA0, S_RDATA1,
    S_FTAR1, S_FTAR2, S_ABORT
  } state_t;

  state_t      state_q, state_d;
  logic        write_q, write_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rbuf_q, rbuf_d;
  logic        err_q, err_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [LW-1:0] lw_cnt_q, lw_cnt_d;
  logic [1:0]  ab_cnt_q, ab_cnt_d;
  logic        lframe_q, lframe_d;
  logic        lad_oe_q, lad_oe_d;
  logic [3:0]  lad_out_q, lad_out_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [7:0]  rsp_rdata_q, rsp_rdata_d;
  logic        sync_abort;

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    err_d       = err_q;
    to_cnt_d    = to_cnt_q;
    lw_cnt_d    = lw_cnt_q;
    ab_cnt_d    = ab_cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    sync_abort  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          write_d = cmd_write_i;
          addr_d  = cmd_addr_i;
          wdata_d = cmd_wdata_i;
          err_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START:   state_d = S_CYCTYPE;
      S_CYCTYPE: state_d = S_ADDR0;
      S_ADDR0:   state_d = S_ADDR1;
      S_ADDR1:   state_d = S_ADDR2;
      S_ADDR2:   state_d = S_ADDR3;
      S_ADDR3:   state_d = write_q ? S_WDATA0 : S_TAR1;
      S_WDATA0:  state_d = S_WDATA1;
      S_WDATA1:  state_d = S_TAR1;
      S_TAR1:    state_d = S_TAR2;
      S_TAR2:    state_d = S_SYNC;
      S_SYNC: begin
        if (lad_bus === 4'b0000 || lad_bus === 4'b1010) begin
          if (lad_bus === 4'b1010) err_d = 1'b1;
          state_d  = write_q ? S_FTAR1 : S_RDATA0;
          to_cnt_d = '0;
          lw_cnt_d = '0;
        end else if (lad_bus === 4'b0110) begin
          // Long waits only have their own limit; the short-wait budget is frozen.
          lw_cnt_d = lw_cnt_q + 1'b1;
          if (int'(lw_cnt_q) + 1 >= LWAIT_MAX) sync_abort = 1'b1;
        end else begin
          lw_cnt_d = '0;
          to_cnt_d = to_cnt_q + 1'b1;
          if (int'(to_cnt_q) + 1 >= SYNC_TIMEOUT) sync_abort = 1'b1;
        end
        if (sync_abort) begin
          state_d  = S_ABORT;
          err_d    = 1'b1;
          ab_cnt_d = '0;
          to_cnt_d = '0;
          lw_cnt_d = '0;
        end
      end
      S_RDATA0: begin
        rbuf_d[3:0] = lad_bus;
        state_d     = S_RDATA1;
      end
      S_RDATA1: begin
        rbuf_d[7:4] = lad_bus;
        state_d     = S_FTAR1;
      end
      S_FTAR1: state_d = S_FTAR2;
      S_FTAR2: begin
        state_d     = S_IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        if (!write_q) rsp_rdata_d = rbuf_q;
      end
      S_ABORT: begin
        ab_cnt_d = ab_cnt_q + 1'b1;
        if (ab_cnt_q == 2'd3) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Pin drive is decoded from the next state so it is registered for the whole clock.
    lframe_d  = 1'b1;
    lad_oe_d  = 1'b0;
    lad_out_d = 4'h0;
    case (state_d)
      S_START:   begin lframe_d = 1'b0; lad_oe_d = 1'b1; lad_out_d = 4'h0; end
      S_CYCTYPE: begin lad_oe_d = 1'b1; lad_out_d = write_d ? 4'h2 : 4'h0; end
      S_ADDR0:   begin lad_oe_d = 1'b1; lad_out_d = addr_d[15:12]; end
      S_ADDR1:   begin lad_oe_d = 1'b1; lad_out_d = addr_d[11:8]; end
      S_ADDR2:   begin lad_oe_d = 1'b1; lad_out_d = addr_d[7:4]; end
      S_ADDR3:   begin lad_oe_d = 1'b1; lad_out_d = addr_d[3:0]; end
      S_WDATA0:  begin lad_oe_d = 1'b1; lad_out_d = wdata_d[3:0]; end
      S_WDATA1:  begin lad_oe_d = 1'b1; lad_out_d = wdata_d[7:4]; end
      S_TAR1:    begin lad_oe_d = 1'b1; lad_out_d = 4'hF; end
      S_ABORT:   begin lframe_d = 1'b0; lad_oe_d = 1'b1; lad_out_d = 4'hF; end
      default:   begin lframe_d = 1'b1; lad_oe_d = 1'b0; lad_out_d = 4'h0; end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!nrst_i) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rbuf_q      <= '0;
      err_q       <= 1'b0;
      to_cnt_q    <= '0;
      lw_cnt_q    <= '0;
      ab_cnt_q    <= '0;
      lframe_q    <= 1'b1;
      lad_oe_q    <= 1'b0;
      lad_out_q   <= 4'h0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rbuf_q      <= rbuf_d;
      err_q       <= err_d;
      to_cnt_q    <= to_cnt_d;
      lw_cnt_q    <= lw_cnt_d;
      ab_cnt_q    <= ab_cnt_d;
      lframe_q    <= lframe_d;
      lad_oe_q    <= lad_oe_d;
      lad_out_q   <= lad_out_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign lad_bus     = lad_oe_q ? lad_out_q : 4'bzzzz;
  assign lframe_o    = lframe_q;
  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = ~cmd_ready_o;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_rdata_o = rsp_rdata_q;

endmodule
